// File: rtl/in_port_buffer.sv
// Per-input-port packet buffer for the MAZE mesh router.
// Holds accepted packets with their [N,W,S,E,B] route vectors and presents the
// head entry to the output arbiters. Each pending direction clears when granted;
// the head retires once every requested direction has been served.
module in_port_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  input  logic [4:0]                   in_route_req,
  output logic [4:0]                   out_req,
  output logic [DATA_W-1:0]            out_data,
  input  logic [4:0]                   out_grant,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         drop_pulse
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [4:0]        pend_mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              nonempty;
  logic              accept;
  logic              store;
  logic              drop;
  logic [4:0]        eff;
  logic [4:0]        remain;
  logic              pop;

  // Head presentation: a mux over stored registers, blanked while empty.
  assign nonempty  = (count != '0);
  assign out_req   = nonempty ? pend_mem[rd_ptr] : 5'b0;
  assign out_data  = nonempty ? data_mem[rd_ptr] : '0;
  assign occupancy = count;
  assign in_ready  = (count != CNT_W'(DEPTH));

  // Push classification: zero-route packets are accepted but never stored.
  assign accept = in_valid & in_ready;
  assign store  = accept & (|in_route_req);
  assign drop   = accept & ~(|in_route_req);

  // Serve: only grants on pending directions count; out_req is 0 when empty.
  assign eff    = out_grant & out_req;
  assign remain = out_req & ~eff;
  assign pop    = (eff != 5'b0) && (remain == 5'b0);

  // Entry storage; the head write and tail write never alias (full blocks push).
  always_ff @(posedge clk) begin
    if (eff != 5'b0) begin
      pend_mem[rd_ptr] <= remain;
    end
    if (store) begin
      data_mem[wr_ptr] <= in_data;
      pend_mem[wr_ptr] <= in_route_req;
    end
  end

  // Pointers, count and the drop pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= drop;
      if (store) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({store, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_in_port_buffer.sv
// Directed bench for in_port_buffer with a queue scoreboard of stored entries.
module tb_in_port_buffer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [4:0]        in_route_req;
  logic [4:0]        out_req;
  logic [DATA_W-1:0] out_data;
  logic [4:0]        out_grant;
  logic [2:0]        occupancy;
  logic              drop_pulse;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [4:0]        pend;
  } entry_t;

  entry_t sb[$];
  int     checks;
  int     failures;

  in_port_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_route_req (in_route_req),
    .out_req      (out_req),
    .out_data     (out_data),
    .out_grant    (out_grant),
    .occupancy    (occupancy),
    .drop_pulse   (drop_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every visible output against the scoreboard.
  task automatic check_outputs(input logic exp_drop);
    logic [4:0]        er;
    logic [DATA_W-1:0] ed;
    er = (sb.size() != 0) ? sb[0].pend : 5'b0;
    ed = (sb.size() != 0) ? sb[0].data : '0;
    check("occupancy", 64'(occupancy), 64'(sb.size()));
    check("in_ready", 64'(in_ready), 64'(sb.size() != DEPTH));
    check("out_req", 64'(out_req), 64'(er));
    check("out_data", 64'(out_data), 64'(ed));
    check("drop_pulse", 64'(drop_pulse), 64'(exp_drop));
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_req", 64'(out_req), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_occupancy", 64'(occupancy), 64'(0));
    check("rst_drop", 64'(drop_pulse), 64'(0));
  endtask

  // Drive one cycle of stimulus, update the scoreboard, then check outputs.
  task automatic cycle(input logic v, input logic [DATA_W-1:0] d,
                       input logic [4:0] r, input logic [4:0] g);
    logic   acc;
    logic   exp_drop;
    entry_t e;
    logic [4:0] eff;
    in_valid     = v;
    in_data      = d;
    in_route_req = r;
    out_grant    = g;
    acc = v && (sb.size() != DEPTH);
    if (v) check("in_ready_pre", 64'(in_ready), 64'(acc));
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      eff = g & sb[0].pend;
      if (eff != 5'b0) begin
        if ((sb[0].pend & ~eff) == 5'b0) void'(sb.pop_front());
        else sb[0].pend = sb[0].pend & ~eff;
      end
    end
    exp_drop = acc && (r == 5'b0);
    if (acc && (r != 5'b0)) begin
      e.data = d;
      e.pend = r;
      sb.push_back(e);
    end
    in_valid  = 1'b0;
    out_grant = 5'b0;
    check_outputs(exp_drop);
  endtask

  function automatic logic [4:0] head_pend();
    return (sb.size() != 0) ? sb[0].pend : 5'b0;
  endfunction

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    in_route_req = 5'b0;
    out_grant    = 5'b0;

    // Reset state before any clock edge.
    #1;
    check_reset_values();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs(1'b0);

    // Single unicast.
    cycle(1'b1, 32'hA5A5_0001, 5'b00010, 5'b00000);
    check("uni_req", 64'(out_req), 64'(5'b00010));
    cycle(1'b0, '0, 5'b0, 5'b00010);
    check("uni_retire_occ", 64'(occupancy), 64'(0));

    // Multicast fork N,S,B with a stray W grant throughout.
    cycle(1'b1, 32'hB0B0_0002, 5'b10101, 5'b01000);
    cycle(1'b0, '0, 5'b0, 5'b11000);
    check("mc_partial_req", 64'(out_req), 64'(5'b00101));
    check("mc_partial_data", 64'(out_data), 64'(32'hB0B0_0002));
    cycle(1'b0, '0, 5'b0, 5'b01101);
    check("mc_retired", 64'(out_req), 64'(0));

    // Fill to DEPTH with no grants; a fifth packet is refused.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'hC000_0000 + 32'(i), 5'(1 << (i % 5)), 5'b0);
    check("full_ready", 64'(in_ready), 64'(0));
    cycle(1'b1, 32'hDEAD_0005, 5'b00001, 5'b0);
    // Pop while full: push still refused, ready returns after the edge.
    cycle(1'b1, 32'hDEAD_0006, 5'b00001, head_pend());
    check("ready_after_pop", 64'(in_ready), 64'(1));

    // Keep pushing while granting the head to walk pointers past the wrap.
    for (int i = 4; i < 8; i++)
      cycle(1'b1, 32'hC000_0000 + 32'(i), 5'(1 << (i % 5)), head_pend());

    // Drain to two, then simultaneous push/pop keeps occupancy at 2.
    cycle(1'b0, '0, 5'b0, head_pend());
    check("occ_two", 64'(occupancy), 64'(2));
    cycle(1'b1, 32'hE000_0009, 5'b01010, head_pend());
    check("pushpop_occ", 64'(occupancy), 64'(2));
    cycle(1'b0, '0, 5'b0, head_pend());
    cycle(1'b0, '0, 5'b0, 5'b00010);
    check("new_tail_data", 64'(out_data), 64'(32'hE000_0009));
    check("new_tail_req", 64'(out_req), 64'(5'b01000));
    cycle(1'b0, '0, 5'b0, head_pend());

    // Zero-route packet: pulse for one cycle, nothing stored.
    cycle(1'b1, 32'hF000_000A, 5'b00000, 5'b0);
    check("drop_seen", 64'(drop_pulse), 64'(1));
    cycle(1'b0, '0, 5'b0, 5'b0);

    // Async reset in the middle of a multicast.
    cycle(1'b1, 32'h1234_5678, 5'b11001, 5'b0);
    cycle(1'b0, '0, 5'b0, 5'b10000);
    check("pre_rst_pend", 64'(out_req), 64'(5'b01001));
    #2;
    rst = 1'b1;
    #1;
    check_reset_values();
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b1, 32'hA5A5_0011, 5'b00100, 5'b0);
    check("post_rst_occ", 64'(occupancy), 64'(1));
    cycle(1'b0, '0, 5'b0, 5'b00100);
    cycle(1'b0, '0, 5'b0, 5'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/in_port_buffer.md
# in_port_buffer

Per-input-port packet buffer sitting directly downstream of the route-computation stage in each MAZE mesh router. It stores each accepted packet together with its 5-bit route request vector [N,W,S,E,B], presents the head entry to the five output arbiters, and handles multicast/broadcast forking. Each destination bit clears independently as its output grants. The head entry retires only when every requested direction has been served.

## Interface
- DEPTH, 4, number of packet entries; power of two, ≥2
- DATA_W, 32, packet payload width in bits; the payload includes the header fields
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream packet valid
- in_ready  output  1  buffer can accept; equals !full
- in_data  input  DATA_W  packet payload
- in_route_req  input  5  route vector from route computation; bit4=N, bit3=W, bit2=S, bit1=E, bit0=B
- out_req  output  5  pending-direction mask of the head entry; 0 when empty
- out_data  output  DATA_W  head payload; valid whenever out_req≠0
- out_grant  input  5  per-direction grant from the output arbiters; same bit order as out_req
- occupancy  output  $clog2(DEPTH+1)  stored entry count
- drop_pulse  output  1  one-cycle pulse: a packet with in_route_req==0 was accepted and discarded

## Operation
- Storage: circular array of DEPTH entries, each holding {payload, pend[4:0]}. Write pointer, read pointer and count are registers. Pointers are $clog2(DEPTH) bits wide and wrap naturally.
- Push: occurs when in_valid & in_ready.
  - If in_route_req≠0: store payload and pend=in_route_req at wr_ptr, increment wr_ptr.
  - If in_route_req==0: store nothing, assert drop_pulse next cycle, count unchanged.
- Serve: eff = out_grant & out_req.
  - Grant bits on non-pending directions are ignored.
  - Grants are ignored entirely when the buffer is empty.
  - Head pend updates to pend & ~eff.
- Pop: if pend & ~eff == 0 and eff≠0, the head retires on the same edge. rd_ptr increments and the next entry becomes head on the following cycle.
- Multicast: multiple pend bits may be granted in the same or in different cycles. out_data stays constant until the final bit clears. Partially served bits never reappear.
- Simultaneous push and pop: count unchanged and both pointers advance.
  - When full, in_ready=0 even if a pop occurs that cycle; there is no same-cycle bypass.
  - When empty, a pushed packet is not visible on out_req until the next cycle; there is no fall-through.
- count: incremented on a storing push without pop, decremented on pop without a storing push.
- Reset mid-operation: all entries are discarded immediately (asynchronous). Pointers and count go to 0 and in-flight multicast state is lost.

## Timing
- Reset values: in_ready=1, out_req=0, out_data=0, occupancy=0, drop_pulse=0, all pointers 0.
- out_req, out_data and occupancy are driven from registers only; no combinational path from in_* or out_grant.
- in_ready depends on registered count only.
- Latency: packet accepted at edge T appears on out_req/out_data after edge T (visible in cycle T+1) if the buffer was empty.
- Grant sampled at edge T: pend update and pop take effect after edge T.
- Throughput: one push and one pop per cycle sustained. A unicast entry granted in the cycle it appears retires in 1 cycle.
- drop_pulse: high for exactly the cycle after the discarding edge.

## Test plan
- Reset then single unicast: push in_route_req=5'b00010, data=0xA5A5_0001. Cycle after: out_req=00010, occupancy=1. Grant 00010: next cycle out_req=0, occupancy=0.
- Multicast fork: push route 5'b10101 (N,S,B). Grant N: out_req=00101, data unchanged. Grant S|B together: entry retires. A stray grant of W throughout has no effect.
- Fill and back-pressure with DEPTH=4: push 4 packets with no grants, then in_ready=0 and occupancy=4. A 5th in_valid is not accepted. Full-cycle grant pops one entry; in_ready returns to 1 the following cycle. Pointer wrap is verified by pushing 8 packets total and checking FIFO order.
- Simultaneous push/pop at occupancy 2: occupancy stays 2. Head advances and the new tail is correct.
- Zero route: push in_route_req=0. drop_pulse=1 for one cycle, occupancy unchanged, no out_req change.
- Async reset mid-multicast: assert rst while head has pend=11001 after partial grant. Outputs go to reset values immediately without a clock edge. After release, the next push behaves as after a clean reset.
